// File: rtl/matrix_stream_fifo.sv
// matrix_stream_fifo: snapshots a ROWS x COLS matrix on start and streams it,
// row- or column-major, through a show-ahead FIFO with valid/ready output.
module matrix_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               transpose,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]    matrix_in,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
  localparam int TOTAL = ROWS * COLS;
  localparam int KW = $clog2(TOTAL + 1);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [KW-1:0] LAST = KW'(TOTAL - 1);
  localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
  localparam logic [CLW-1:0] C_MAX = CLW'(COLS - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] snap [ROWS][COLS];
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic tr;
  logic [RW-1:0] r;
  logic [CLW-1:0] c;
  logic [KW-1:0] push_cnt, pop_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, r_end, c_end, load;

  assign out_valid = count != '0;
  assign out_data = mem[rd_ptr];
  assign fifo_count = count;
  assign busy = state == STREAM || state == DRAIN;
  assign done = state == DONE;
  assign push = state == STREAM && count != FULL;
  assign pop = out_valid && out_ready;
  assign r_end = r == R_MAX;
  assign c_end = c == C_MAX;
  assign load = state == IDLE && start;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STREAM;
      STREAM:  if (push && push_cnt == LAST) state_nx = DRAIN;
      // the final pop empties the FIFO, so DONE lands the cycle after it
      DRAIN:   if (pop && pop_cnt == LAST && count == CW'(1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tr <= 1'b0;
      r <= '0;
      c <= '0;
      push_cnt <= '0;
      pop_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        pop_cnt <= pop_cnt + KW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        push_cnt <= push_cnt + KW'(1);
        r <= (tr || c_end) ? (r_end ? '0 : r + RW'(1)) : r;
        c <= (!tr || r_end) ? (c_end ? '0 : c + CLW'(1)) : c;
      end
      if (load) begin
        tr <= transpose;
        r <= '0;
        c <= '0;
        push_cnt <= '0;
        pop_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= snap[r][c];
    if (load)
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          snap[i][j] <= matrix_in[(i*COLS+j)*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_matrix_stream_fifo.sv
// tb_matrix_stream_fifo: randomized check of matrix_stream_fifo against a
// queue-based reference of the expected element order.
module tb_matrix_stream_fifo;
  localparam int DW = 32;
  localparam int R = 4;
  localparam int C = 4;
  localparam int D = 8;
  localparam int N = R * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic transpose = 1'b0;
  logic out_ready = 1'b0;
  logic [N*DW-1:0] matrix_in = '0;
  logic [DW-1:0] out_data;
  logic out_valid, busy, done;
  logic [$clog2(D+1)-1:0] fifo_count;
  int total = 0;
  int bad = 0;

  matrix_stream_fifo #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .transpose(transpose),
    .matrix_in(matrix_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pattern();
    logic [N*DW-1:0] m;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        m[(i*C+j)*DW +: DW] = DW'(16 * i + j);
    return m;
  endfunction

  function automatic logic [N*DW-1:0] rand_mat();
    logic [N*DW-1:0] m;
    for (int i = 0; i < N; i++) m[i*DW +: DW] = $urandom;
    return m;
  endfunction

  // mode: 0 ready=1, 1 stall 20 cycles, 2 random ready, 3 random + restart attempt, 4 reset mid-run
  task automatic run(input logic [N*DW-1:0] m, input logic tp, input int mode);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pd, e;
    logic pv;
    int n_acc, done_cnt, done_t, last_acc;
    n_acc = 0; done_cnt = 0; done_t = -1; last_acc = -1; pv = 1'b0; pd = '0;
    if (!tp) begin
      for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_q.push_back(m[(i*C+j)*DW +: DW]);
    end else begin
      for (int j = 0; j < C; j++) for (int i = 0; i < R; i++) exp_q.push_back(m[(i*C+j)*DW +: DW]);
    end
    @(negedge clk);
    matrix_in = m; transpose = tp; start = 1'b1; out_ready = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      start = 1'b0;
      transpose = 1'($urandom);
      out_ready = (mode == 0 || mode == 4) ? 1'b1 : mode == 1 ? (t >= 21) : 1'($urandom);
      if (mode == 3 && t == 4) begin
        start = 1'b1;
        matrix_in = ~m;
      end
      if (mode == 4 && t == 7) begin
        reset = 1'b1;
        out_ready = 1'b0;
      end
      if (mode == 4 && t == 8) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
      end
      if (mode == 4 && t >= 8) chk("rst_nodone", done, 0);
      if (mode == 4 && t == 12) break;
      if (mode == 0 && t == 1) chk("first_valid_low", out_valid, 0);
      if (mode == 0) chk("busy", busy, t <= N + 1);
      if (pv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (mode == 1) chk("count_le_depth", fifo_count <= D, 1);
      if (mode == 1 && t == 20) begin
        chk("sat_count", fifo_count, D);
        chk("sat_data", out_data, exp_q[0]);
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_t = t;
          chk("done_time", t, mode == 0 ? N + 2 : last_acc + 1);
        end
      end
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) chk("extra_elem", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("data", out_data, e);
        end
        if (mode == 0) chk("no_gap", t, 2 + n_acc);
        if (mode == 1) chk("no_gap_stall", t, 21 + n_acc);
        n_acc++;
        last_acc = t;
      end
      pv = out_valid && !out_ready && !reset;
      pd = out_data;
      if (done_t > 0 && t == done_t + 3) break;
    end
    if (mode != 4) begin
      chk("n_acc", n_acc, N);
      chk("one_done", done_cnt, 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", fifo_count, 0);
    reset = 1'b0;
    run(pattern(), 1'b0, 0);
    run(pattern(), 1'b1, 0);
    run(pattern(), 1'b0, 1);
    repeat (3) run(rand_mat(), 1'($urandom), 2);
    run(rand_mat(), 1'b0, 3);
    run(rand_mat(), 1'b1, 3);
    run(pattern(), 1'b0, 4);
    run(pattern(), 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
